// File: rtl/tx_pulse_sequencer.sv
// Burst/PRT sequencer for the transmit sync generator: Barker chip timing per PRT,
// with config changes applied only at PRT boundaries. Optional rx_blank output: TX_SEQ_BLANK_EN.
module tx_pulse_sequencer #(
    parameter int CNT_W      = 32,
    parameter int NP_W       = 16,
    parameter int BARKER_LEN = 11,
    parameter logic [BARKER_LEN-1:0] BARKER_CODE = 11'b11100010010
`ifdef TX_SEQ_BLANK_EN
    ,
    parameter int GUARD_CYC  = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_prt,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NP_W-1:0]  cfg_npulses,
    input  logic             cfg_wr,
    input  logic             arm,
    input  logic             abort,
    output logic             start,
    output logic [CNT_W-1:0] PRT_count_wire,
    output logic [CNT_W-1:0] T_count_wire,
    output logic             prt_tick,
    output logic             chip_valid,
    output logic             chip_phase,
    output logic [NP_W-1:0]  pulse_idx,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
`ifdef TX_SEQ_BLANK_EN
    ,
    output logic             rx_blank
`endif
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    localparam int XW   = CNT_W + 4;
    localparam int CI_W = $clog2(BARKER_LEN + 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_prt_cnt;
    logic [CNT_W-1:0] r_chip_cnt;
    logic [CI_W-1:0]  r_chip_idx;
    logic [NP_W-1:0]  r_pulse_idx;
    logic             r_done;
    logic             r_cfg_err;

    logic [CNT_W-1:0] r_act_prt;
    logic [CNT_W-1:0] r_act_period;
    logic [NP_W-1:0]  r_act_np;
    logic [CNT_W-1:0] r_pend_prt;
    logic [CNT_W-1:0] r_pend_period;
    logic [NP_W-1:0]  r_pend_np;
    logic             r_pend_flag;

    logic             w_run;
    logic [CNT_W-1:0] w_sel_prt;
    logic [CNT_W-1:0] w_sel_period;
    logic [XW-1:0]    w_sel_chips;
    logic             w_sel_ok;
    logic             w_prt_end;
    logic             w_last_pulse;
    logic             w_copy;
    logic [BARKER_LEN-1:0] w_code_sh;

    // Config that the next arm or PRT wrap would use: pending if present, else active.
    assign w_sel_prt    = r_pend_flag ? r_pend_prt    : r_act_prt;
    assign w_sel_period = r_pend_flag ? r_pend_period : r_act_period;
    assign w_sel_chips  = XW'(BARKER_LEN) * {4'b0000, w_sel_period};
    assign w_sel_ok     = (w_sel_prt >= CNT_W'(2)) && (w_sel_period != '0) &&
                          (w_sel_chips <= {4'b0000, w_sel_prt});

    assign w_run        = (r_state == S_RUN);
    assign w_prt_end    = (r_prt_cnt == r_act_prt - CNT_W'(1));
    assign w_last_pulse = (r_act_np != '0) && (r_pulse_idx == r_act_np - NP_W'(1));

    assign w_copy = !abort && r_pend_flag && w_sel_ok &&
                    ((!w_run && arm) || (w_run && w_prt_end && !w_last_pulse));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_prt_cnt     <= '0;
            r_chip_cnt    <= '0;
            r_chip_idx    <= '0;
            r_pulse_idx   <= '0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_act_prt     <= '0;
            r_act_period  <= '0;
            r_act_np      <= '0;
            r_pend_prt    <= '0;
            r_pend_period <= '0;
            r_pend_np     <= '0;
            r_pend_flag   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            if (w_copy) begin
                r_act_prt    <= r_pend_prt;
                r_act_period <= r_pend_period;
                r_act_np     <= r_pend_np;
                r_pend_flag  <= 1'b0;
            end
            // A write in the same cycle as a copy wins: the new values stay pending.
            if (cfg_wr) begin
                r_pend_prt    <= cfg_prt;
                r_pend_period <= cfg_period;
                r_pend_np     <= cfg_npulses;
                r_pend_flag   <= 1'b1;
            end

            if (abort) begin
                r_state     <= S_IDLE;
                r_prt_cnt   <= '0;
                r_chip_cnt  <= '0;
                r_chip_idx  <= '0;
                r_pulse_idx <= '0;
            end else if (!w_run) begin
                if (arm) begin
                    if (w_sel_ok) begin
                        r_state     <= S_RUN;
                        r_prt_cnt   <= '0;
                        r_chip_cnt  <= '0;
                        r_chip_idx  <= '0;
                        r_pulse_idx <= '0;
                    end else begin
                        r_cfg_err <= 1'b1;
                    end
                end
            end else if (w_prt_end) begin
                if (w_last_pulse) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_prt_cnt   <= '0;
                    r_chip_cnt  <= '0;
                    r_chip_idx  <= '0;
                    r_pulse_idx <= r_pulse_idx + NP_W'(1);
                    if (r_pend_flag && !w_sel_ok) begin
                        r_cfg_err <= 1'b1;
                    end
                end
            end else begin
                r_prt_cnt <= r_prt_cnt + CNT_W'(1);
                if (r_chip_idx < CI_W'(BARKER_LEN)) begin
                    if (r_chip_cnt == r_act_period - CNT_W'(1)) begin
                        r_chip_cnt <= '0;
                        r_chip_idx <= r_chip_idx + CI_W'(1);
                    end else begin
                        r_chip_cnt <= r_chip_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Shifting the code left puts the current chip in the MSB position.
    assign w_code_sh = BARKER_CODE << r_chip_idx;

    assign start          = w_run;
    assign busy           = w_run;
    assign prt_tick       = w_run && (r_prt_cnt == '0);
    assign chip_valid     = w_run && (r_chip_idx < CI_W'(BARKER_LEN));
    assign chip_phase     = chip_valid && w_code_sh[BARKER_LEN-1];
    assign pulse_idx      = r_pulse_idx;
    assign done           = r_done;
    assign cfg_err        = r_cfg_err;
    assign PRT_count_wire = r_act_prt;
    assign T_count_wire   = r_act_period;

`ifdef TX_SEQ_BLANK_EN
    logic [XW-1:0] w_act_chips;
    assign w_act_chips = XW'(BARKER_LEN) * {4'b0000, r_act_period};
    // Clipping at the PRT end is implicit since prt_cnt never reaches prt.
    assign rx_blank    = w_run && ({4'b0000, r_prt_cnt} < w_act_chips + XW'(GUARD_CYC));
`endif

endmodule

// File: tb/tb_tx_pulse_sequencer.sv
// Directed bench for tx_pulse_sequencer with hand-computed expectations.
// Build with TX_SEQ_BLANK_EN defined to also cover rx_blank (GUARD_CYC=4).
module tb_tx_pulse_sequencer;

    localparam int CNT_W = 32;
    localparam int NP_W  = 16;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cfg_prt;
    logic [CNT_W-1:0] cfg_period;
    logic [NP_W-1:0]  cfg_npulses;
    logic             cfg_wr;
    logic             arm;
    logic             abort;
    logic             start;
    logic [CNT_W-1:0] PRT_count_wire;
    logic [CNT_W-1:0] T_count_wire;
    logic             prt_tick;
    logic             chip_valid;
    logic             chip_phase;
    logic [NP_W-1:0]  pulse_idx;
    logic             busy;
    logic             done;
    logic             cfg_err;
`ifdef TX_SEQ_BLANK_EN
    logic             rx_blank;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];
    logic code_seq [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    tx_pulse_sequencer #(
        .CNT_W(CNT_W),
        .NP_W (NP_W)
`ifdef TX_SEQ_BLANK_EN
        ,
        .GUARD_CYC(4)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_prt       (cfg_prt),
        .cfg_period    (cfg_period),
        .cfg_npulses   (cfg_npulses),
        .cfg_wr        (cfg_wr),
        .arm           (arm),
        .abort         (abort),
        .start         (start),
        .PRT_count_wire(PRT_count_wire),
        .T_count_wire  (T_count_wire),
        .prt_tick      (prt_tick),
        .chip_valid    (chip_valid),
        .chip_phase    (chip_phase),
        .pulse_idx     (pulse_idx),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
`ifdef TX_SEQ_BLANK_EN
        ,
        .rx_blank      (rx_blank)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: inputs set before this call are sampled at the edge; outputs are read #1 later.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input int prt, input int period, input int np);
        cfg_prt     = CNT_W'(prt);
        cfg_period  = CNT_W'(period);
        cfg_npulses = NP_W'(np);
        cfg_wr      = 1'b1;
        step();
        cfg_wr      = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_start"}, start, 0);
        check_eq({tag, "_tick"}, prt_tick, 0);
        check_eq({tag, "_valid"}, chip_valid, 0);
        check_eq({tag, "_phase"}, chip_phase, 0);
        check_eq({tag, "_done"}, done, 0);
    endtask

    initial begin
        int hi_cnt;
        int blank_cnt;
        rst = 1'b1; cfg_prt = '0; cfg_period = '0; cfg_npulses = '0;
        cfg_wr = 1'b0; arm = 1'b0; abort = 1'b0;
        step(3);
        rst = 1'b0;
        step();
        check_idle("rst");
        check_eq("rst_pidx", pulse_idx, 0);
        check_eq("rst_prt", PRT_count_wire, 0);
        check_eq("rst_per", T_count_wire, 0);
        check_eq("rst_err", cfg_err, 0);

        // Burst of 2 pulses, prt=40, period=3
        do_cfg(40, 3, 2);
        check_eq("t1_prt_pend", PRT_count_wire, 0);
        do_arm();
        check_eq("t1_prt_act", PRT_count_wire, 40);
        check_eq("t1_per_act", T_count_wire, 3);
        hi_cnt = 0;
        blank_cnt = 0;
        for (int t = 0; t <= 80; t++) begin
            int ptc;
            ptc = t % 40;
            if (t < 80) begin
                if (ptc == 0) begin
                    for (int c = 0; c < 11; c++)
                        for (int r = 0; r < 3; r++) exp_q.push_back(code_seq[c]);
                end
                check_eq("t1_tick", prt_tick, (ptc == 0));
                check_eq("t1_valid", chip_valid, (ptc < 33));
                check_eq("t1_pidx", pulse_idx, t / 40);
                check_eq("t1_busy", busy, 1);
                check_eq("t1_done", done, 0);
                if (ptc < 33) check_eq("t1_phase", chip_phase, exp_q.pop_front());
                else          check_eq("t1_phase_off", chip_phase, 0);
                if (t < 40 && chip_valid) hi_cnt++;
`ifdef TX_SEQ_BLANK_EN
                if (t < 40 && rx_blank) blank_cnt++;
`endif
            end else begin
                check_eq("t1_done_end", done, 1);
                check_eq("t1_busy_end", busy, 0);
                check_eq("t1_start_end", start, 0);
                check_eq("t1_valid_end", chip_valid, 0);
                check_eq("t1_pidx_end", pulse_idx, 1);
            end
            step();
        end
        check_eq("t1_valid_cnt", hi_cnt, 33);
`ifdef TX_SEQ_BLANK_EN
        check_eq("t1_blank_cnt", blank_cnt, 37);
`endif
        check_eq("t1_done_once", done, 0);
        check_eq("t1_pidx_hold", pulse_idx, 1);

        // Invalid config (33 > 30) rejected at arm
        do_cfg(30, 3, 2);
        do_arm();
        check_eq("t2_err", cfg_err, 1);
        check_eq("t2_busy", busy, 0);
        step();
        check_eq("t2_err_once", cfg_err, 0);
        check_eq("t2_busy2", busy, 0);
        check_eq("t2_prt_keep", PRT_count_wire, 40);

        // Continuous mode, prt change mid-PRT applies at next tick
        do_cfg(40, 3, 0);
        do_arm();
        check_eq("t3_tick0", prt_tick, 1);
        step(10);
        do_cfg(50, 3, 0);
        check_eq("t3_prt_old", PRT_count_wire, 40);
        do_arm();
        check_eq("t3_rearm_tick", prt_tick, 0);
        check_eq("t3_rearm_busy", busy, 1);
        check_eq("t3_rearm_pidx", pulse_idx, 0);
        step(27);
        check_eq("t3_prt_old39", PRT_count_wire, 40);
        check_eq("t3_tick39", prt_tick, 0);
        step();
        check_eq("t3_tick40", prt_tick, 1);
        check_eq("t3_prt_new", PRT_count_wire, 50);
        check_eq("t3_pidx1", pulse_idx, 1);
        step(49);
        check_eq("t3_tick89", prt_tick, 0);
        step();
        check_eq("t3_tick90", prt_tick, 1);
        check_eq("t3_pidx2", pulse_idx, 2);

        // Abort together with arm at prt_cnt=10
        step(10);
        abort = 1'b1;
        arm   = 1'b1;
        step();
        abort = 1'b0;
        arm   = 1'b0;
        check_idle("t4");
        check_eq("t4_pidx", pulse_idx, 0);
        check_eq("t4_err", cfg_err, 0);
        step(3);
        check_eq("t4_done_later", done, 0);
        check_eq("t4_busy_later", busy, 0);

        // Exact fit: prt=33, period=3, no gap between PRTs
        do_cfg(33, 3, 2);
        do_arm();
        step(32);
        check_eq("t5_valid32", chip_valid, 1);
        check_eq("t5_phase32", chip_phase, 0);
        check_eq("t5_tick32", prt_tick, 0);
        step();
        check_eq("t5_tick33", prt_tick, 1);
        check_eq("t5_valid33", chip_valid, 1);
        check_eq("t5_phase33", chip_phase, 1);
        check_eq("t5_pidx33", pulse_idx, 1);
        step(33);
        check_eq("t5_done66", done, 1);
        check_eq("t5_busy66", busy, 0);

        // Reset mid-burst stops the burst and clears config
        do_arm();
        check_eq("t6_busy", busy, 1);
        step(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t6");
        check_eq("t6_prt", PRT_count_wire, 0);
        check_eq("t6_per", T_count_wire, 0);
        do_arm();
        check_eq("t6_err", cfg_err, 1);
        check_eq("t6_busy_after", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
